// File: rtl/tx_pkg.sv
// Register map, FSM state type and R_TRANSMIT field positions for the TX transmit controller.
package tx_pkg;

   localparam logic [15:0] R_TRANSMIT    = 16'h0050;
   localparam logic [15:0] R_TX_BYTE_CNT = 16'h0051;
   localparam logic [15:0] R_TX_BUF      = 16'h0052;

   localparam int unsigned START_BIT = 0;
   localparam int unsigned RETRY_LSB = 4;
   localparam int unsigned RETRY_MSB = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2
   } tx_state_e;

   function automatic logic [1:0] retry_field(input logic [15:0] data);
      return data[RETRY_MSB:RETRY_LSB];
   endfunction

endpackage

// File: rtl/tx_transmit_ctrl_if.sv
// Register-write bus, PHY byte stream, PHY outcome and status signals of tx_transmit_ctrl.
interface tx_transmit_ctrl_if;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_ready;
   logic        phy_ack;
   logic        phy_fail;
   logic        busy;
   logic        tx_success;
   logic        tx_failed;
   logic        tx_discarded;
   logic        buf_ovf;

   modport slave (
      input  wr_en, wr_addr, wr_data, tx_ready, phy_ack, phy_fail,
      output tx_byte, tx_valid, tx_last, busy, tx_success, tx_failed, tx_discarded, buf_ovf
   );

   modport master (
      output wr_en, wr_addr, wr_data, tx_ready, phy_ack, phy_fail,
      input  tx_byte, tx_valid, tx_last, busy, tx_success, tx_failed, tx_discarded, buf_ovf
   );
endinterface

// File: rtl/tx_msg_buffer.sv
// DEPTH x 8 transmit message store: append-only write pointer, sticky overflow flag,
// combinational read port addressed by the controller's read pointer.
module tx_msg_buffer
   import tx_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             wr,
   input  logic [7:0]       wdata,
   input  logic             clear,
   input  logic [CNT_W-1:0] rptr,
   output logic [7:0]       rdata,
   output logic             ovf
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [CNT_W-1:0] wptr;
   logic             full;
   logic             unused_rptr_hi;

   assign full = (wptr == CNT_W'(DEPTH));

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         wptr <= '0;
         ovf  <= 1'b0;
      end else if (clear) begin
         wptr <= '0;
         ovf  <= 1'b0;
      end else if (wr) begin
         if (full) ovf  <= 1'b1;
         else      wptr <= wptr + CNT_W'(1);
      end
   end

   // Contents survive clear and reset; only the pointer is rewound.
   always_ff @(posedge CLK) begin
      if (wr && !full) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata          = mem[rptr[AW-1:0]];
   assign unused_rptr_hi = ^rptr[CNT_W-1:AW];
endmodule

// File: rtl/tx_transmit_ctrl.sv
// Register-driven message transmitter with retry on PHY failure.
// Optional acknowledge watchdog enabled by macro TX_TIMEOUT_EN.
module tx_transmit_ctrl
   import tx_pkg::*;
#(
   parameter int unsigned DEPTH          = 32,
   parameter int unsigned CNT_W          = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input logic               CLK,
   input logic               Reset,
   tx_transmit_ctrl_if.slave bus
);
   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] byte_cnt_q, rptr_q, rptr_d, cnt_req;
   logic [1:0]       retry_q, retry_d;
   logic             success_d, failed_d, discarded_d, buf_clear;
   logic             success_q, failed_q, discarded_q;
   logic [7:0]       rd_byte;
   logic             ovf, idle, xmit_wr, buf_wr, cnt_wr, last_beat, timeout_hit, fail_evt;
   logic             unused_wr_hi;

   assign idle         = (state_q == IDLE);
   assign xmit_wr      = bus.wr_en && (bus.wr_addr == R_TRANSMIT);
   assign buf_wr       = idle && bus.wr_en && (bus.wr_addr == R_TX_BUF);
   assign cnt_wr       = idle && bus.wr_en && (bus.wr_addr == R_TX_BYTE_CNT);
   assign cnt_req      = bus.wr_data[CNT_W-1:0];
   assign last_beat    = (rptr_q == byte_cnt_q - CNT_W'(1));
   assign fail_evt     = bus.phy_fail || timeout_hit;
   assign unused_wr_hi = ^bus.wr_data[15:8];

   tx_msg_buffer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_buf (
      .CLK   (CLK),
      .Reset (Reset),
      .wr    (buf_wr),
      .wdata (bus.wr_data[7:0]),
      .clear (buf_clear),
      .rptr  (rptr_q),
      .rdata (rd_byte),
      .ovf   (ovf)
   );

`ifdef TX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt;

   // Leaving WAIT_ACK (including a retry) rewinds the watchdog for the next entry.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)                    wait_cnt <= '0;
      else if (state_q != WAIT_ACK) wait_cnt <= '0;
      else if (!timeout_hit)        wait_cnt <= wait_cnt + TW'(1);
   end

   assign timeout_hit = (state_q == WAIT_ACK) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) byte_cnt_q <= '0;
      else if (cnt_wr) byte_cnt_q <= (cnt_req > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cnt_req;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         rptr_q      <= '0;
         retry_q     <= '0;
         success_q   <= 1'b0;
         failed_q    <= 1'b0;
         discarded_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rptr_q      <= rptr_d;
         retry_q     <= retry_d;
         success_q   <= success_d;
         failed_q    <= failed_d;
         discarded_q <= discarded_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rptr_d      = rptr_q;
      retry_d     = retry_q;
      success_d   = 1'b0;
      failed_d    = 1'b0;
      discarded_d = 1'b0;
      buf_clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (xmit_wr && bus.wr_data[START_BIT]) begin
               if (byte_cnt_q != '0) begin
                  retry_d = retry_field(bus.wr_data);
                  rptr_d  = '0;
                  state_d = SEND;
               end else begin
                  failed_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               rptr_d = rptr_q + CNT_W'(1);
               if (last_beat) state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (bus.phy_ack) begin
               success_d = 1'b1;
               buf_clear = 1'b1;
               state_d   = IDLE;
            end else if (fail_evt) begin
               if (retry_q != 2'd0) begin
                  retry_d = retry_q - 2'd1;
                  rptr_d  = '0;
                  state_d = SEND;
               end else begin
                  failed_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (xmit_wr && !idle) discarded_d = 1'b1;
   end

   assign bus.tx_valid     = (state_q == SEND);
   assign bus.tx_last      = bus.tx_valid && last_beat;
   assign bus.tx_byte      = bus.tx_valid ? rd_byte : 8'h00;
   assign bus.busy         = !idle;
   assign bus.tx_success   = success_q;
   assign bus.tx_failed    = failed_q;
   assign bus.tx_discarded = discarded_q;
   assign bus.buf_ovf      = ovf;
endmodule

// File: doc/tx_transmit_ctrl.md
Name: tx_transmit_ctrl

Overview:
Downstream consumer of register writes decoded by the I2C slave interface of the TX path. Holds a byte-wide transmit buffer written through register writes. On a write to R_TRANSMIT (0x0050) it streams the buffered message bytes to the PHY encoder over a valid/ready handshake, then waits for PHY acknowledge and retries on failure. Reports outcome as single-cycle status pulses.

Parameters:
DEPTH, 32, transmit buffer size in bytes (power of 2, at most 64)
CNT_W, 6, width of the byte-count and pointer registers
TIMEOUT_CYCLES, 1000, acknowledge watchdog limit (used only with TX_TIMEOUT_EN)

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
wr_en  in  1  one-cycle register-write strobe from the I2C slave
wr_addr  in  16  register address
wr_data  in  16  register write data
tx_byte  out  8  byte presented to the PHY encoder
tx_valid  out  1  tx_byte is valid
tx_last  out  1  tx_byte is the final byte of the message
tx_ready  in  1  PHY accepts the byte this cycle
phy_ack  in  1  one-cycle pulse: message delivered
phy_fail  in  1  one-cycle pulse: delivery failed
busy  out  1  high in any state other than IDLE
tx_success  out  1  one-cycle pulse on delivery
tx_failed  out  1  one-cycle pulse when retries are exhausted or the byte count is zero
tx_discarded  out  1  one-cycle pulse when an R_TRANSMIT write is rejected
buf_ovf  out  1  sticky flag: a buffer write was attempted while the buffer was full

Behaviour:
- Reset values: all outputs 0. State IDLE. wptr, rptr, byte_cnt and retry count are 0. Reset mid-transmission aborts immediately and does not generate a status pulse.
- Register map:
  - 0x0050 R_TRANSMIT: wr_data[0] is start; wr_data[5:4] is the retry count.
  - 0x0051 R_TX_BYTE_CNT: byte_cnt is set to wr_data[CNT_W-1:0], saturated at DEPTH.
  - 0x0052 R_TX_BUF: wr_data[7:0] is written to buf[wptr], then wptr increments.
  - Other addresses are ignored.
- Buffer writes and count writes:
  - Honoured only in IDLE; ignored otherwise.
  - A write to R_TX_BUF with wptr==DEPTH is dropped and sets buf_ovf. buf_ovf clears on a successful transmission or on reset.
- State machine: IDLE, SEND, WAIT_ACK.
- IDLE:
  - R_TRANSMIT write with start=1 and byte_cnt>0: latch the retry count, set rptr=0, go to SEND. tx_valid is asserted on the next cycle (latency 1).
  - Start=1 with byte_cnt==0: pulse tx_failed on the next cycle and stay in IDLE.
  - Start=0: no effect.
- SEND:
  - tx_byte=buf[rptr], tx_valid=1, tx_last=(rptr==byte_cnt-1).
  - tx_byte must stay stable until tx_valid&&tx_ready.
  - On handshake: rptr increments. On a handshake with tx_last, go to WAIT_ACK; tx_valid deasserts in the same cycle as the transition.
- WAIT_ACK:
  - phy_ack: pulse tx_success, clear wptr and buf_ovf, go to IDLE.
  - phy_fail with retries>0: decrement retries, set rptr=0, go to SEND. The buffer contents are reused.
  - phy_fail with retries==0: pulse tx_failed, go to IDLE. The buffer is kept.
  - phy_ack and phy_fail in the same cycle: phy_ack wins.
  - phy_ack or phy_fail outside WAIT_ACK: ignored.
- R_TRANSMIT write while busy: ignored, and tx_discarded pulses on the next cycle. This includes a write in the same cycle as the final ack.
- Status pulses are registered and last exactly one cycle.

Optional Feature:
TX_TIMEOUT_EN:
- When defined: a counter runs in WAIT_ACK and clears on entry. Reaching TIMEOUT_CYCLES is treated exactly as phy_fail, including retries.
- When not defined: WAIT_ACK waits indefinitely and the counter is not synthesized.

Decomposition:
- Package tx_pkg: register address constants R_TRANSMIT, R_TX_BYTE_CNT and R_TX_BUF; the state encoding (IDLE=2'd0, SEND=2'd1, WAIT_ACK=2'd2); bit positions of the R_TRANSMIT fields.
- Sub-module tx_msg_buffer: DEPTH x 8 storage with write pointer, full flag and overflow detection, and a combinational read port at rptr.
- The state machine, retry counter and status logic stay in tx_transmit_ctrl.

Test Plan:
- Write 0x00A5 then 0x005A to 0x0052, 0x0002 to 0x0051, then 0x0001 to 0x0050, with tx_ready=1 -> tx_valid rises 1 cycle after the write; bytes A5 then 5A; tx_last on 5A. Then pulse phy_ack -> tx_success pulses once, busy=0.
- Same 2-byte message with wr_data=0x0011 (1 retry) and tx_ready toggling 1/0 -> tx_byte holds while stalled. phy_fail resends A5,5A; a second phy_fail -> tx_failed pulses once.
- Write 0x0001 to 0x0050 during SEND -> tx_discarded pulses; the stream is unaffected.
- byte_cnt=0, then start -> tx_failed pulses next cycle; tx_valid never asserts.
- 33 writes to 0x0052 with DEPTH=32 -> buf_ovf=1 and the 33rd byte is absent. Assert Reset mid-SEND -> all outputs 0 and no status pulse.
- With TX_TIMEOUT_EN and TIMEOUT_CYCLES=10, no ack -> tx_failed pulses 10 cycles after entering WAIT_ACK.
